branch_resolver: RTL and testbench

- Consumer side of the {N,V,Z} flag register: evaluates the 3-bit branch condition code against the flag register output and produces the taken decision and the redirect PC.
- Keeps a scoreboard of in-flight flag-writing instructions. A branch waits until every older flag write has landed in the flag register before it samples the flags.
- Sits between decode (branch issue) and the fetch PC mux (redirect).

---
 rtl/branch_resolver.sv | 130 +++++++++++++
 tb/tb_branch_resolver.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Branch resolver: holds a branch until every older flag writer has retired, then
// evaluates its condition against {N,V,Z} and produces the taken decision and redirect PC.
module branch_resolver #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic             br_is_reg,
  input  logic [15:0]      pc_plus2,
  input  logic [8:0]       imm9,
  input  logic [15:0]      reg_target,
  input  logic [2:0]       flag_out,
  input  logic             flag_wr_issue,
  input  logic             flag_wr_retire,
  output logic             stall,
  output logic             resolved,
  output logic             taken,
  output logic [15:0]      redirect_pc,
  output logic [CNT_W-1:0] pending,
  output logic             sb_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] pending_next;
  logic             sb_fault;
  logic             accept;
  logic [15:0]      br_target;
  logic [2:0]       cond_q;
  logic [15:0]      pc_q;
  logic [15:0]      target_q;
  logic             cond_met;
  logic             flag_n;
  logic             flag_v;
  logic             flag_z;

  assign br_ready = (state == IDLE);
  assign stall    = (state == WAIT) || (state == RESOLVE);
  assign accept   = br_valid && (state == IDLE);

  // B offsets are word offsets, so the sign-extended immediate is shifted left by one.
  assign br_target = br_is_reg ? reg_target
                               : pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};

  assign flag_n = flag_out[2];
  assign flag_v = flag_out[1];
  assign flag_z = flag_out[0];

  // Saturating scoreboard: an overflowing issue or underflowing retire leaves the count alone.
  always_comb begin
    pending_next = pending;
    sb_fault     = 1'b0;
    if (flag_wr_issue && !flag_wr_retire) begin
      if (pending == CNT_MAX) sb_fault = 1'b1;
      else                    pending_next = pending + CNT_ONE;
    end else if (flag_wr_retire && !flag_wr_issue) begin
      if (pending == '0) sb_fault = 1'b1;
      else               pending_next = pending - CNT_ONE;
    end
  end

  always_comb begin
    cond_met = 1'b1;
    case (cond_q)
      3'b000:  cond_met = !flag_z;
      3'b001:  cond_met = flag_z;
      3'b010:  cond_met = !flag_z && !flag_n;
      3'b011:  cond_met = flag_n;
      3'b100:  cond_met = flag_z || (!flag_z && !flag_n);
      3'b101:  cond_met = flag_n || flag_z;
      3'b110:  cond_met = flag_v;
      default: cond_met = 1'b1;
    endcase
  end

  // In WAIT, a retire that drains the count releases the branch right after the flags land.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (br_cond == 3'b111 || (pending == '0 && !flag_wr_retire)) state_next = RESOLVE;
          else                                                           state_next = WAIT;
        end
      end
      WAIT:    if (pending_next == '0) state_next = RESOLVE;
      RESOLVE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      sb_err      <= 1'b0;
      resolved    <= 1'b0;
      taken       <= 1'b0;
      redirect_pc <= '0;
      cond_q      <= '0;
      pc_q        <= '0;
      target_q    <= '0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      resolved <= (state == RESOLVE);
      if (sb_fault) sb_err <= 1'b1;
      if (accept) begin
        cond_q   <= br_cond;
        pc_q     <= pc_plus2;
        target_q <= br_target;
      end
      if (state == RESOLVE) begin
        taken       <= cond_met;
        redirect_pc <= cond_met ? target_q : pc_q;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of branch and scoreboard behaviour.
module tb_branch_resolver;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_cond;
  logic             br_is_reg;
  logic [15:0]      pc_plus2;
  logic [8:0]       imm9;
  logic [15:0]      reg_target;
  logic [2:0]       flag_out;
  logic             flag_wr_issue;
  logic             flag_wr_retire;
  logic             stall;
  logic             resolved;
  logic             taken;
  logic [15:0]      redirect_pc;
  logic [CNT_W-1:0] pending;
  logic             sb_err;

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 0;

  // Model state: outstanding writers, sticky error, and the single branch in flight.
  int          m_cnt;
  bit          m_err;
  bit          m_busy;
  bit          m_waiting;
  bit          m_eval_now;
  bit          m_last_accept;
  logic [2:0]  m_cond;
  logic [15:0] m_pc;
  logic [15:0] m_target;
  bit          exp_resolved;
  bit          exp_taken;
  logic [15:0] exp_pc;

  logic [7:0] sweep_mask [8] = '{8'h55, 8'hAA, 8'h05, 8'hF0, 8'hAF, 8'hFA, 8'hCC, 8'hFF};

  branch_resolver #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_is_reg(br_is_reg), .pc_plus2(pc_plus2), .imm9(imm9), .reg_target(reg_target),
    .flag_out(flag_out), .flag_wr_issue(flag_wr_issue), .flag_wr_retire(flag_wr_retire),
    .stall(stall), .resolved(resolved), .taken(taken), .redirect_pc(redirect_pc),
    .pending(pending), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic bit cond_holds(input logic [2:0] c, input logic [2:0] f);
    bit n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || (!z && !n);
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    int next_cnt;
    int offset;
    if (rst) begin
      m_cnt = 0; m_err = 0; m_busy = 0; m_waiting = 0; m_eval_now = 0; m_last_accept = 0;
      m_cond = '0; m_pc = '0; m_target = '0;
      exp_resolved = 0; exp_taken = 0; exp_pc = '0;
      return;
    end
    next_cnt = m_cnt;
    if (flag_wr_issue && !flag_wr_retire) begin
      if (m_cnt == CNT_MAX) m_err = 1; else next_cnt = m_cnt + 1;
    end else if (flag_wr_retire && !flag_wr_issue) begin
      if (m_cnt == 0) m_err = 1; else next_cnt = m_cnt - 1;
    end
    exp_resolved  = 0;
    m_last_accept = 0;
    if (m_eval_now) begin
      exp_taken    = cond_holds(m_cond, flag_out);
      exp_pc       = exp_taken ? m_target : m_pc;
      exp_resolved = 1;
      m_eval_now   = 0;
      m_busy       = 0;
    end else if (m_waiting) begin
      if (next_cnt == 0) begin
        m_waiting  = 0;
        m_eval_now = 1;
      end
    end else if (!m_busy && br_valid) begin
      offset   = $signed(imm9) * 2;
      m_cond   = br_cond;
      m_pc     = pc_plus2;
      m_target = br_is_reg ? reg_target : 16'((int'(pc_plus2) + offset) & 32'hFFFF);
      m_busy   = 1;
      m_last_accept = 1;
      if (br_cond == 3'd7 || (m_cnt == 0 && !flag_wr_retire)) m_eval_now = 1;
      else                                                    m_waiting  = 1;
    end
    m_cnt = next_cnt;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check_output("resolved", resolved, exp_resolved);
      check_output("taken", taken, exp_taken);
      check_output("redirect_pc", redirect_pc, exp_pc);
      check_output("pending", pending, m_cnt);
      check_output("sb_err", sb_err, m_err);
      check_output("br_ready", br_ready, !m_busy);
      check_output("stall", stall, m_busy);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    br_valid = 0; br_cond = '0; br_is_reg = 0; pc_plus2 = '0; imm9 = '0; reg_target = '0;
    flag_wr_issue = 0; flag_wr_retire = 0;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic offer(input logic [2:0] c, input logic is_reg, input logic [15:0] pc,
                       input logic [8:0] imm, input logic [15:0] rt);
    br_valid = 1; br_cond = c; br_is_reg = is_reg; pc_plus2 = pc; imm9 = imm; reg_target = rt;
  endtask

  task automatic apply_stimulus(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rst            = ($urandom_range(0, 99) == 0);
      flag_wr_issue  = ($urandom_range(0, 3) == 0);
      flag_wr_retire = (m_cnt > 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 31) == 0);
      flag_out       = 3'($urandom);
      if (!br_valid || m_last_accept) begin
        br_valid   = ($urandom_range(0, 2) != 0);
        br_cond    = 3'($urandom);
        br_is_reg  = 1'($urandom);
        pc_plus2   = 16'($urandom);
        imm9       = 9'($urandom);
        reg_target = 16'($urandom);
      end
    end
  endtask

  initial begin
    idle_inputs();
    flag_out = '0;
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    tick();
    rst = 0;
    check_en = 1;

    // B EQ with no hazard, backward offset of -2 words
    flag_out = 3'b001;
    offer(3'b001, 0, 16'h0010, 9'h1FE, 16'h0000);
    tick();
    br_valid = 0;
    check_output("nohaz_stall_t1", stall, 1);
    tick();
    check_output("nohaz_resolved", resolved, 1);
    check_output("nohaz_taken", taken, 1);
    check_output("nohaz_pc", redirect_pc, 16'h000C);

    // NE behind an older writer: must see the flags written by its retire
    flag_wr_issue = 1;
    tick();
    flag_wr_issue = 0;
    offer(3'b000, 0, 16'h0100, 9'h004, 16'h0000);
    tick();
    br_valid = 0;
    check_output("haz_stall_t1", stall, 1);
    tick();
    flag_wr_retire = 1;
    check_output("haz_stall_t2", stall, 1);
    tick();
    flag_wr_retire = 0;
    flag_out = 3'b000;
    check_output("haz_stall_t3", stall, 1);
    check_output("haz_resolved_early", resolved, 0);
    tick();
    check_output("haz_resolved", resolved, 1);
    check_output("haz_taken", taken, 1);
    check_output("haz_pc", redirect_pc, 16'h0108);
    check_output("haz_stall_t4", stall, 0);

    // Unconditional BR ignores two outstanding writers
    flag_wr_issue = 1;
    tick();
    tick();
    flag_wr_issue = 0;
    check_output("unc_pending", pending, 2);
    offer(3'b111, 1, 16'h1234, 9'h000, 16'hBEEF);
    tick();
    br_valid = 0;
    tick();
    check_output("unc_resolved", resolved, 1);
    check_output("unc_taken", taken, 1);
    check_output("unc_pc", redirect_pc, 16'hBEEF);

    // Reset while a branch is waiting aborts it silently
    flag_wr_retire = 1;
    tick();
    flag_wr_retire = 0;
    flag_out = 3'b000;
    offer(3'b001, 0, 16'h0200, 9'h010, 16'h0000);
    tick();
    br_valid = 0;
    tick();
    rst = 1;
    check_output("rstw_stall", stall, 1);
    tick();
    rst = 0;
    check_output("rstw_ready", br_ready, 1);
    check_output("rstw_pending", pending, 0);
    check_output("rstw_resolved", resolved, 0);
    check_output("rstw_taken", taken, 0);
    check_output("rstw_pc", redirect_pc, 16'h0000);
    tick();
    check_output("rstw_resolved_after", resolved, 0);

    // Scoreboard saturation and sticky error
    do_reset();
    flag_wr_issue = 1;
    for (int i = 0; i < 4; i++) tick();
    check_output("sb_pending_sat", pending, 3);
    check_output("sb_err_set", sb_err, 1);
    flag_wr_retire = 1;
    tick();
    flag_wr_issue = 0;
    flag_wr_retire = 0;
    check_output("sb_pending_both", pending, 3);
    check_output("sb_err_sticky", sb_err, 1);

    // Every condition code against every flag combination
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [7:0] mask;
        bit         want;
        mask = sweep_mask[c];
        want = mask[f];
        flag_out = 3'(f);
        offer(3'(c), 0, 16'h0100, 9'h0FF, 16'h0000);
        tick();
        br_valid = 0;
        tick();
        check_output("sweep_resolved", resolved, 1);
        check_output("sweep_taken", taken, want);
        check_output("sweep_pc", redirect_pc, want ? 16'h02FE : 16'h0100);
      end
    end

    apply_stimulus(4000);

    tick();
    idle_inputs();
    rst = 0;
    for (int i = 0; i < 10; i++) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
